// File: rtl/branch_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_pkg
//   Shared constants for the branch condition unit: default data width,
//   LEGv8 condition-code encodings, branch-kind encodings, decision-slot
//   state encodings and the packed NZCV flag layout.
// -----------------------------------------------------------------------------
package branch_cond_unit_pkg;

   // Default data / target address width.
   localparam int WORD_DEFAULT = 64;

   // LEGv8 B.cond condition codes.
   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_HS = 4'd2,
      COND_LO = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Branch kinds carried on br_kind.
   typedef enum logic [1:0] {
      KIND_BCOND = 2'b00,
      KIND_CBZ   = 2'b01,
      KIND_CBNZ  = 2'b10,
      KIND_B     = 2'b11
   } kind_e;

   // Decision-slot states; plain constants keep the encoding visible to
   // legacy tools and waveform viewers.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Flag layout: bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   // Assemble the ALU status bits into the architectural flag order.
   function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                       input logic c, input logic v);
      nzcv_t f;
      f.n = n;
      f.z = z;
      f.c = c;
      f.v = v;
      return f;
   endfunction

endpackage : branch_cond_unit_pkg

// File: rtl/branch_cond_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_cond_eval
//   Purely combinational LEGv8 condition evaluator.
//   Ports:
//     flags  in  nzcv_t  N,Z,C,V flags to test
//     cond   in  cond_e  condition code
//     taken  out 1       condition holds
// -----------------------------------------------------------------------------
module branch_cond_unit_cond_eval
   import branch_cond_unit_pkg::*;
(
   input  nzcv_t flags,
   input  cond_e cond,
   output logic  taken
);

   logic n_eq_v;

   assign n_eq_v = (flags.n == flags.v);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // taken unassigned, which would otherwise infer a latch.
      taken = 1'b0;
      case (cond)
         COND_EQ: taken =  flags.z;
         COND_NE: taken = ~flags.z;
         COND_HS: taken =  flags.c;
         COND_LO: taken = ~flags.c;
         COND_MI: taken =  flags.n;
         COND_PL: taken = ~flags.n;
         COND_VS: taken =  flags.v;
         COND_VC: taken = ~flags.v;
         COND_HI: taken =  flags.c & ~flags.z;
         COND_LS: taken = ~flags.c |  flags.z;
         COND_GE: taken =  n_eq_v;
         COND_LT: taken = ~n_eq_v;
         COND_GT: taken = ~flags.z &  n_eq_v;
         COND_LE: taken =  flags.z | ~n_eq_v;
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b1;   // NV behaves as "always" in LEGv8
         default: taken = 1'b0;
      endcase
   end

endmodule : branch_cond_unit_cond_eval

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
//   Holds the NZCV flag register, resolves branch requests (B.cond, CBZ,
//   CBNZ, B) and presents the decision to fetch through a one-entry
//   valid/ready slot. Latency request->decision is one cycle; a consumed
//   slot can be refilled on the same edge (no bubble).
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     alu_*             ALU status of the current result
//     flag_we           set-flags instruction commits this cycle
//     br_valid/br_ready branch request handshake
//     br_kind           00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//     br_cond           condition code (B.cond only)
//     br_operand_zero   tested register is zero (CBZ/CBNZ only)
//     br_target         branch target
//     dec_valid/ready   decision handshake to fetch
//     dec_taken         decision: branch taken
//     dec_target        registered target
//     flags             registered {N,Z,C,V}
//
//   Configuration macro:
//     BRANCH_FLAG_FORWARD_EN  when defined, a B.cond accepted in the same
//                             cycle as flag_we evaluates against the
//                             incoming ALU flags instead of the registered
//                             ones.
// -----------------------------------------------------------------------------
module branch_cond_unit
   import branch_cond_unit_pkg::*;
#(
   parameter int WORD = WORD_DEFAULT
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_zero,
   input  logic            alu_negative,
   input  logic            alu_carry,
   input  logic            alu_overflow,
   input  logic            flag_we,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [1:0]      br_kind,
   input  logic [3:0]      br_cond,
   input  logic            br_operand_zero,
   input  logic [WORD-1:0] br_target,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic            dec_taken,
   output logic [WORD-1:0] dec_target,
   output logic [3:0]      flags
);

   logic [0:0] state;
   nzcv_t      flags_q;
   nzcv_t      alu_flags;
   nzcv_t      eval_flags;
   logic       cond_taken;
   logic       req_taken;
   logic       accept;

   assign alu_flags = pack_nzcv(alu_negative, alu_zero, alu_carry, alu_overflow);

   // ---------------------------------------------------------------------------
   // Flag source for condition evaluation
   // ---------------------------------------------------------------------------
`ifdef BRANCH_FLAG_FORWARD_EN
   // Forward the flags being written this cycle so a dependent B.cond sees
   // them without waiting for the register update.
   assign eval_flags = flag_we ? alu_flags : flags_q;
`else
   assign eval_flags = flags_q;
`endif

   branch_cond_unit_cond_eval u_cond_eval (
      .flags (eval_flags),
      .cond  (cond_e'(br_cond)),
      .taken (cond_taken)
   );

   always_comb begin
      req_taken = 1'b0;
      case (kind_e'(br_kind))
         KIND_BCOND: req_taken = cond_taken;
         KIND_CBZ:   req_taken =  br_operand_zero;
         KIND_CBNZ:  req_taken = ~br_operand_zero;
         KIND_B:     req_taken = 1'b1;
         default:    req_taken = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Handshake: slot can take a request when empty, or when fetch drains it
   // this same cycle. Nothing is accepted while reset is asserted.
   // ---------------------------------------------------------------------------
   assign br_ready = rst_n & ((state == ST_EMPTY) | dec_ready);
   assign accept   = br_valid & br_ready;

   // ---------------------------------------------------------------------------
   // Flag register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its inputs as they were before the edge.
         flags_q <= '0;
      end else if (flag_we) begin
         flags_q <= alu_flags;
      end
   end

   // ---------------------------------------------------------------------------
   // Decision slot
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         dec_taken  <= 1'b0;
         // NOTE: the target is datapath, but it is reset anyway because the
         // decision outputs must read as zero whenever the slot is cleared.
         dec_target <= '0;
      end else begin
         if (accept) begin
            state      <= ST_FULL;
            dec_taken  <= req_taken;
            dec_target <= br_target;
         end else if ((state == ST_FULL) && dec_ready) begin
            state <= ST_EMPTY;
         end
         // FULL with dec_ready=0 holds everything: accept is low then.
      end
   end

   assign dec_valid = (state == ST_FULL);
   assign flags     = flags_q;

endmodule : branch_cond_unit

// File: tb/tb_branch_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_cond_unit
//   Directed self-checking bench for branch_cond_unit. Expected values are
//   hand-derived from the condition table; the summary line reports counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_cond_unit;
   import branch_cond_unit_pkg::*;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_zero, alu_negative, alu_carry, alu_overflow;
   logic          flag_we;
   logic          br_valid;
   logic          br_ready;
   logic [1:0]    br_kind;
   logic [3:0]    br_cond;
   logic          br_operand_zero;
   logic [W-1:0]  br_target;
   logic          dec_valid;
   logic          dec_ready;
   logic          dec_taken;
   logic [W-1:0]  dec_target;
   logic [3:0]    flags;

   int errors = 0;
   int checks = 0;

   branch_cond_unit #(.WORD(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_zero        (alu_zero),
      .alu_negative    (alu_negative),
      .alu_carry       (alu_carry),
      .alu_overflow    (alu_overflow),
      .flag_we         (flag_we),
      .br_valid        (br_valid),
      .br_ready        (br_ready),
      .br_kind         (br_kind),
      .br_cond         (br_cond),
      .br_operand_zero (br_operand_zero),
      .br_target       (br_target),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_taken       (dec_taken),
      .dec_target      (dec_target),
      .flags           (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle 1ns so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [3:0] nzcv);
      {alu_negative, alu_zero, alu_carry, alu_overflow} = nzcv;
   endtask

   // Load the flag register with no branch in flight.
   task automatic load_flags(input logic [3:0] nzcv);
      br_valid = 1'b0;
      flag_we  = 1'b1;
      set_alu(nzcv);
      step();
      flag_we  = 1'b0;
   endtask

   // Present one request for exactly one edge (slot must be ready).
   task automatic issue(input logic [1:0] kind, input logic [3:0] cond,
                        input logic opz, input logic [63:0] tgt);
      br_valid        = 1'b1;
      br_kind         = kind;
      br_cond         = cond;
      br_operand_zero = opz;
      br_target       = tgt;
      step();
      br_valid        = 1'b0;
   endtask

   // Reference condition table written directly from the LEGv8 definitions.
   function automatic logic exp_cond(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   logic        fwd_exp;
   logic        held_taken;
   logic [3:0]  nz;
   logic [3:0]  cc;

   initial begin
`ifdef BRANCH_FLAG_FORWARD_EN
      fwd_exp = 1'b1;
`else
      fwd_exp = 1'b0;
`endif
      // ---------------- reset with activity on the inputs ----------------
      rst_n = 1'b0;
      flag_we = 1'b1;
      set_alu(4'b1111);
      br_valid = 1'b1;
      br_kind = 2'b11;
      br_cond = 4'd0;
      br_operand_zero = 1'b0;
      br_target = 64'hDEAD;
      dec_ready = 1'b1;
      step();
      step();
      check("rst_flags",      flags,      4'b0000);
      check("rst_dec_valid",  dec_valid,  1'b0);
      check("rst_br_ready",   br_ready,   1'b0);
      check("rst_dec_taken",  dec_taken,  1'b0);
      check("rst_dec_target", dec_target, 64'h0);
      flag_we  = 1'b0;
      br_valid = 1'b0;
      #2 rst_n = 1'b1;
      #1;

      // ---------------- EQ / NE with Z=1 ----------------
      load_flags(4'b0110);          // N=0 Z=1 C=1 V=0
      check("flags_load", flags, 4'b0110);
      check("empty_ready", br_ready, 1'b1);
      br_valid = 1'b1; br_kind = KIND_BCOND; br_cond = COND_EQ; br_target = 64'h100;
      step();
      check("eq_valid",  dec_valid,  1'b1);
      check("eq_taken",  dec_taken,  1'b1);
      check("eq_target", dec_target, 64'h100);
      // Back-to-back: slot drained and refilled on the same edge.
      br_cond = COND_NE; br_target = 64'h200;
      check("full_ready", br_ready, 1'b1);
      step();
      br_valid = 1'b0;
      check("ne_valid",  dec_valid,  1'b1);
      check("ne_taken",  dec_taken,  1'b0);
      check("ne_target", dec_target, 64'h200);
      step();
      check("drain_empty", dec_valid, 1'b0);

      // ---------------- signed compares over all NZCV ----------------
      for (int f = 0; f < 16; f++) begin
         nz = 4'(f);
         load_flags(nz);
         for (int c = 10; c < 14; c++) begin
            cc = 4'(c);
            issue(KIND_BCOND, cc, 1'b0, 64'(f * 16 + c));
            check($sformatf("sweep_f%0d_c%0d", f, c), dec_taken, exp_cond(nz, cc));
         end
      end

      // ---------------- every condition at two flag patterns ----------------
      for (int p = 0; p < 2; p++) begin
         nz = (p == 0) ? 4'b1001 : 4'b0110;
         load_flags(nz);
         for (int c = 0; c < 16; c++) begin
            cc = 4'(c);
            issue(KIND_BCOND, cc, 1'b0, 64'h40 + 64'(c));
            check($sformatf("all_p%0d_c%0d", p, c), dec_taken, exp_cond(nz, cc));
         end
      end
      step();

      // ---------------- stall: dec_ready=0 for 3 cycles ----------------
      load_flags(4'b0100);          // Z=1
      dec_ready = 1'b0;
      issue(KIND_BCOND, COND_EQ, 1'b0, 64'h300);
      check("stall_first_taken",  dec_taken,  1'b1);
      check("stall_first_target", dec_target, 64'h300);
      held_taken = dec_taken;
      br_valid = 1'b1; br_kind = KIND_BCOND; br_cond = COND_EQ; br_target = 64'h400;
      flag_we = 1'b1; set_alu(4'b0000);      // flags change under the stall
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_ready_%0d", i),  br_ready,   1'b0);
         step();
         check($sformatf("stall_valid_%0d", i),  dec_valid,  1'b1);
         check($sformatf("stall_taken_%0d", i),  dec_taken,  held_taken);
         check($sformatf("stall_target_%0d", i), dec_target, 64'h300);
      end
      flag_we = 1'b0;
      check("stall_flags_upd", flags, 4'b0000);
      dec_ready = 1'b1;
      #1;
      check("release_ready", br_ready, 1'b1);
      step();
      br_valid = 1'b0;
      check("release_target", dec_target, 64'h400);
      check("release_taken",  dec_taken,  1'b0);   // EQ against Z=0
      step();

      // ---------------- same-edge flag write + B.cond ----------------
      load_flags(4'b0000);
      flag_we = 1'b1; set_alu(4'b0100);
      issue(KIND_BCOND, COND_EQ, 1'b0, 64'h500);
      flag_we = 1'b0;
      check("fwd_taken", dec_taken, fwd_exp);
      check("fwd_flags", flags,     4'b0100);
      step();

      // ---------------- CBZ / CBNZ / B ----------------
      issue(KIND_CBZ,  COND_NE, 1'b1, 64'h600);
      check("cbz_1",  dec_taken, 1'b1);
      issue(KIND_CBNZ, COND_NV, 1'b1, 64'h604);
      check("cbnz_1", dec_taken, 1'b0);
      issue(KIND_CBZ,  COND_AL, 1'b0, 64'h608);
      check("cbz_0",  dec_taken, 1'b0);
      issue(KIND_CBNZ, COND_EQ, 1'b0, 64'h60C);
      check("cbnz_0", dec_taken, 1'b1);
      issue(KIND_B,    COND_NE, 1'b0, 64'h610);   // flags Z=1, cond ignored
      check("b_uncond",        dec_taken,  1'b1);
      check("b_uncond_target", dec_target, 64'h610);
      step();

      // ---------------- reset mid-handshake ----------------
      dec_ready = 1'b0;
      issue(KIND_B, COND_AL, 1'b0, 64'h700);
      check("pre_rst_valid", dec_valid, 1'b1);
      br_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",  dec_valid,  1'b0);
      check("mid_rst_target", dec_target, 64'h0);
      check("mid_rst_taken",  dec_taken,  1'b0);
      check("mid_rst_ready",  br_ready,   1'b0);
      check("mid_rst_flags",  flags,      4'b0000);
      step();
      check("in_rst_valid", dec_valid, 1'b0);
      br_target = 64'h800; br_kind = KIND_B;
      #2 rst_n = 1'b1;
      #1;
      check("post_rst_ready", br_ready, 1'b1);
      step();
      br_valid = 1'b0;
      check("first_accept_valid",  dec_valid,  1'b1);
      check("first_accept_target", dec_target, 64'h800);
      dec_ready = 1'b1;
      step();
      check("final_empty", dec_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_branch_cond_unit

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter: WORD, default `WORD (64), data/target width.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 alu_zero / alu_negative / alu_carry / alu_overflow  in  1 each  ALU status of the current result.
REQ-005 flag_we  in  1  set-flags instruction (ADDS/SUBS/ANDS) commits this cycle.
REQ-006 br_valid  in  1  branch request present.
REQ-007 br_ready  out  1  unit can accept a request this cycle.
REQ-008 br_kind  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B.
REQ-009 br_cond  in  4  LEGv8 condition code (B.cond only).
REQ-010 br_operand_zero  in  1  tested register equals zero (CBZ/CBNZ only).
REQ-011 br_target  in  WORD  branch target address.
REQ-012 dec_valid  out  1  decision held for the fetch stage.
REQ-013 dec_ready  in  1  fetch stage consumes the decision.
REQ-014 dec_taken  out  1  branch taken.
REQ-015 dec_target  out  WORD  registered br_target.
REQ-016 flags  out  4  registered {N,Z,C,V}.

Function
REQ-017 flags SHALL load {alu_negative, alu_zero, alu_carry, alu_overflow} on the clk edge where flag_we=1; otherwise hold.
REQ-018 Two states SHALL exist: EMPTY (dec_valid=0) and FULL (dec_valid=1).
REQ-019 br_ready SHALL equal (state==EMPTY) or dec_ready, combinationally.
REQ-020 Accept = br_valid and br_ready; on accept, state becomes FULL next cycle with dec_taken/dec_target valid (latency 1).
REQ-021 FULL with dec_ready=1 and no accept SHALL go to EMPTY; with accept SHALL stay FULL and load the new decision (back-to-back, no bubble).
REQ-022 FULL with dec_ready=0 SHALL hold dec_taken, dec_target unchanged regardless of flag_we.
REQ-023 Conditions: EQ0 Z; NE1 !Z; HS2 C; LO3 !C; MI4 N; PL5 !N; VS6 V; VC7 !V; HI8 C&!Z; LS9 !C|Z; GE10 N==V; LT11 N!=V; GT12 !Z&(N==V); LE13 Z|(N!=V); AL14 and NV15 always taken.
REQ-024 CBZ taken iff br_operand_zero; CBNZ taken iff !br_operand_zero; kind 11 always taken; br_cond ignored for kinds other than 00.
REQ-025 Flags used for evaluation SHALL be the registered flags unless REQ-031 applies.

Reset
REQ-026 rst_n low SHALL immediately force state EMPTY, dec_valid=0, dec_taken=0, dec_target=0, flags=4'b0000.
REQ-027 Reset mid-handshake SHALL discard the held decision; no request is accepted while rst_n is low (br_ready=0).
REQ-028 First accept allowed on the first clk edge after rst_n deasserts.

Configuration
REQ-029 Macro BRANCH_FLAG_FORWARD_EN controls same-cycle flag forwarding.
REQ-030 Undefined: a B.cond accepted in the same cycle as flag_we SHALL evaluate against the old registered flags.
REQ-031 Defined: in that case it SHALL evaluate against the incoming ALU flags; flags register update unchanged.

Structure
REQ-032 Shared constants package/header (constants.vh) SHALL hold condition-code encodings, br_kind encodings and state encodings; WORD comes from there.
REQ-033 One sub-module cond_eval (combinational: NZCV + cond -> taken) is natural; everything else inline.

Verification
REQ-034 Reset: rst_n=0 with flag_we=1, br_valid=1 -> flags=0000, dec_valid=0, br_ready=0.
REQ-035 flag_we with N=0,Z=1,C=1,V=0, next cycle B.cond EQ target 0x100 -> one cycle later dec_valid=1, dec_taken=1, dec_target=0x100; same with NE -> dec_taken=0.
REQ-036 GE/LT/GT/LE sweep over all 16 NZCV values -> dec_taken matches REQ-023 table for each.
REQ-037 dec_ready=0 for 3 cycles with br_valid=1 -> br_ready=0, outputs stable; dec_ready=1 -> next request accepted that edge, new decision next cycle.
REQ-038 flag_we (Z=1) and B.cond EQ accepted same edge, prior Z=0 -> dec_taken=0 without macro, 1 with BRANCH_FLAG_FORWARD_EN.
REQ-039 CBZ with br_operand_zero=1 -> taken; CBNZ same input -> not taken; kind 11 with br_cond=NE, Z=1 -> taken.
